cam_ctrl: RTL and testbench

Sequencer and two-port arbiter for the 16-entry content-addressable memory. Two requesters issue lookup or insert operations over valid/ready handshakes. The controller grants one operation at a time round-robin and drives the CAM strobes: lookup first, then write on an insert miss. It allocates CAM slots sequentially and returns one response per accepted request.

---
 rtl/cam_ctrl_if.sv | 27 ++
 rtl/cam_ctrl.sv | 129 ++++++++++++
 tb/tb_cam_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_ctrl_if.sv
// Request/response bundle between the two requesters, the response consumer and cam_ctrl.
// The master side drives requests and rsp_ready; the slave side is the controller.
interface cam_ctrl_if #(
  parameter int KEY_W = 8,
  parameter int IDX_W = 5
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_op;
  logic [2*KEY_W-1:0] req_key;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic               rsp_hit;
  logic [IDX_W-1:0]   rsp_idx;
  logic               rsp_err;

  modport master (
    output req_valid, req_op, req_key, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_hit, rsp_idx, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_key, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_hit, rsp_idx, rsp_err
  );
endinterface

// File: rtl/cam_ctrl.sv
// Round-robin sequencer for a 16-entry CAM: lookup first, write on an insert miss,
// sequential slot allocation and one response per accepted request.
module cam_ctrl #(
  parameter int NB_MEM = 16,
  parameter int KEY_W  = 8,
  parameter int IDX_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  cam_ctrl_if.slave        bus,
  output logic [IDX_W-1:0] count,
  output logic             full,
  output logic             cam_enable,
  output logic             cam_write,
  output logic [IDX_W-1:0] cam_addr,
  output logic [KEY_W-1:0] cam_data,
  input  logic [IDX_W-1:0] cam_out,
  input  logic             cam_found
);

  typedef enum logic [2:0] {IDLE, LOOK, CHK, WR, RESP} state_t;

  localparam logic [IDX_W-1:0] NB_MEM_IDX = IDX_W'(NB_MEM);

  state_t           state, state_nxt;
  logic             last_grant;
  logic             grant_vld;
  logic             grant_id;
  logic [KEY_W-1:0] grant_key;
  logic             op_q;
  logic [KEY_W-1:0] key_q;
  logic [1:0]       ready_c;

  // When both requesters are waiting, the one not served last wins.
  always_comb begin
    grant_vld = |bus.req_valid;
    if (&bus.req_valid)
      grant_id = ~last_grant;
    else
      grant_id = bus.req_valid[1];
    grant_key = grant_id ? bus.req_key[2*KEY_W-1:KEY_W] : bus.req_key[KEY_W-1:0];
  end

  assign full          = (count == NB_MEM_IDX);
  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = (state == RESP);

  always_comb begin
    state_nxt  = state;
    ready_c    = 2'b00;
    cam_enable = 1'b0;
    cam_write  = 1'b0;
    cam_addr   = '0;
    cam_data   = '0;
    case (state)
      IDLE: begin
        // Gated by rst so a requester never sees an accept that reset discards.
        if (grant_vld && !rst) begin
          ready_c   = grant_id ? 2'b10 : 2'b01;
          state_nxt = (grant_key == '0) ? RESP : LOOK;
        end
      end
      LOOK: begin
        cam_enable = 1'b1;
        cam_data   = key_q;
        state_nxt  = CHK;
      end
      CHK: begin
        if (cam_found || !op_q || full)
          state_nxt = RESP;
        else
          state_nxt = WR;
      end
      WR: begin
        cam_write = 1'b1;
        cam_addr  = count;
        cam_data  = key_q;
        state_nxt = RESP;
      end
      RESP: begin
        if (bus.rsp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response fields change only in IDLE/CHK/WR, so they hold steady throughout RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      last_grant  <= 1'b1;
      op_q        <= 1'b0;
      key_q       <= '0;
      bus.rsp_id  <= 1'b0;
      bus.rsp_hit <= 1'b0;
      bus.rsp_idx <= '0;
      bus.rsp_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            last_grant  <= grant_id;
            op_q        <= bus.req_op[grant_id];
            key_q       <= grant_key;
            bus.rsp_id  <= grant_id;
            bus.rsp_hit <= 1'b0;
            bus.rsp_idx <= '0;
            bus.rsp_err <= (grant_key == '0);
          end
        end
        CHK: begin
          bus.rsp_hit <= cam_found;
          bus.rsp_idx <= cam_found ? cam_out : '0;
          bus.rsp_err <= !cam_found && op_q && full;
        end
        WR: begin
          bus.rsp_idx <= count;
          if (count != NB_MEM_IDX)
            count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed bench for cam_ctrl with a behavioural 16-entry CAM hanging off the strobes.
module tb_cam_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] count;
  logic       full;
  logic       cam_enable;
  logic       cam_write;
  logic [4:0] cam_addr;
  logic [7:0] cam_data;
  logic [4:0] cam_out;
  logic       cam_found;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  logic [7:0] cam_mem [16];
  logic       srch_hit;
  logic [4:0] srch_idx;

  cam_ctrl_if #(.KEY_W(8), .IDX_W(5)) bus ();

  cam_ctrl #(.NB_MEM(16), .KEY_W(8), .IDX_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .count      (count),
    .full       (full),
    .cam_enable (cam_enable),
    .cam_write  (cam_write),
    .cam_addr   (cam_addr),
    .cam_data   (cam_data),
    .cam_out    (cam_out),
    .cam_found  (cam_found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CAM: registered lowest-index match, cleared together with the controller.
  always_comb begin
    srch_hit = 1'b0;
    srch_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (cam_mem[i] == cam_data) begin
        srch_hit = 1'b1;
        srch_idx = 5'(i);
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) cam_mem[i] <= '0;
      cam_found <= 1'b0;
      cam_out   <= '0;
    end else begin
      if (cam_write && cam_addr < 5'd16) cam_mem[cam_addr[3:0]] <= cam_data;
      cam_found <= cam_enable && srch_hit;
      cam_out   <= cam_enable ? srch_idx : '0;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One request from requester id; exp_idx < 0 skips the index check.
  task automatic apply_stimulus(input string tag, input int id, input logic op, input logic [7:0] key,
                                input int exp_lat, input logic exp_hit, input int exp_idx,
                                input logic exp_err, input int exp_en, input int exp_wr, input int hold);
    int n, en, wr, oth;
    logic [10:0] exp_hold;
    en = 0;
    wr = 0;
    oth = 1 - id;
    bus.rsp_ready = (hold == 0);
    bus.req_valid[id] = 1'b1;
    bus.req_op[id] = op;
    bus.req_key[id*8 +: 8] = key;
    #1;
    check_output({tag, " ready"}, 32'(bus.req_ready), (id == 1) ? 32'd2 : 32'd1);
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 20) begin
      if (cam_write) begin
        wr++;
        wr_addr = cam_addr;
        wr_data = cam_data;
      end
      if (cam_enable) en++;
      @(negedge clk);
      n++;
    end
    check_output({tag, " latency"}, n, exp_lat);
    check_output({tag, " id"}, 32'(bus.rsp_id), id);
    check_output({tag, " hit"}, 32'(bus.rsp_hit), 32'(exp_hit));
    check_output({tag, " err"}, 32'(bus.rsp_err), 32'(exp_err));
    if (exp_idx >= 0) check_output({tag, " idx"}, 32'(bus.rsp_idx), exp_idx);
    check_output({tag, " enables"}, en, exp_en);
    check_output({tag, " writes"}, wr, exp_wr);
    if (exp_wr == 1) begin
      check_output({tag, " wr_addr"}, 32'(wr_addr), exp_idx);
      check_output({tag, " wr_data"}, 32'(wr_data), 32'(key));
    end
    if (hold > 0) begin
      exp_hold = {1'b1, 1'(id), exp_hit, exp_err, 5'(exp_idx), 2'b00};
      bus.req_valid[oth] = 1'b1;
      bus.req_op[oth] = 1'b0;
      bus.req_key[oth*8 +: 8] = key;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check_output({tag, " held"},
                     32'({bus.rsp_valid, bus.rsp_id, bus.rsp_hit, bus.rsp_err, bus.rsp_idx, bus.req_ready}),
                     32'(exp_hold));
      end
      bus.req_valid[oth] = 1'b0;
      bus.rsp_ready = 1'b1;
    end
    @(negedge clk);
    check_output({tag, " rsp_valid drop"}, 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    logic [1:0] g;
    int n, seen;
    logic [1:0] exp_g  [4];
    logic       exp_id [4];
    logic       exp_h  [4];
    logic [4:0] exp_i  [4];

    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_op    = 2'b00;
    bus.req_key   = '0;
    bus.rsp_ready = 1'b1;
    wr_addr = '0;
    wr_data = '0;

    apply_reset();
    $display("[TB] reset values");
    check_output("reset count", 32'(count), 0);
    check_output("reset full", 32'(full), 0);
    check_output("reset rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_hit, bus.rsp_err, bus.rsp_idx}), 0);
    check_output("reset strobes", 32'({bus.req_ready, cam_enable, cam_write, cam_addr, cam_data}), 0);

    $display("[TB] insert then lookups");
    apply_stimulus("ins 5a", 0, 1'b1, 8'h5A, 4, 1'b0, 0, 1'b0, 1, 1, 0);
    check_output("count after 5a", 32'(count), 1);
    apply_stimulus("look 5a", 0, 1'b0, 8'h5A, 3, 1'b1, 0, 1'b0, 1, 0, 0);
    apply_stimulus("look 33", 1, 1'b0, 8'h33, 3, 1'b0, 0, 1'b0, 1, 0, 0);
    check_output("count after lookups", 32'(count), 1);

    $display("[TB] both requesters inserting");
    exp_g  = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_h  = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp_i  = '{5'd1, 5'd2, 5'd1, 5'd2};
    bus.req_op  = 2'b11;
    bus.req_key = {8'h22, 8'h11};
    bus.req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      g = 2'b00;
      n = 0;
      while (!bus.rsp_valid && n < 20) begin
        if (bus.req_ready != 2'b00) g = bus.req_ready;
        @(negedge clk);
        n++;
      end
      check_output($sformatf("arb grant %0d", k), 32'(g), 32'(exp_g[k]));
      check_output($sformatf("arb id %0d", k), 32'(bus.rsp_id), 32'(exp_id[k]));
      check_output($sformatf("arb hit %0d", k), 32'(bus.rsp_hit), 32'(exp_h[k]));
      check_output($sformatf("arb idx %0d", k), 32'(bus.rsp_idx), 32'(exp_i[k]));
      if (k == 3) bus.req_valid = 2'b00;
      @(negedge clk);
    end
    check_output("count after arb", 32'(count), 3);

    $display("[TB] key zero");
    apply_stimulus("look key0", 1, 1'b0, 8'h00, 1, 1'b0, 0, 1'b1, 0, 0, 0);
    apply_stimulus("ins key0", 0, 1'b1, 8'h00, 1, 1'b0, 0, 1'b1, 0, 0, 0);
    check_output("count after key0", 32'(count), 3);

    $display("[TB] response backpressure");
    apply_stimulus("hold 22", 0, 1'b0, 8'h22, 3, 1'b1, 2, 1'b0, 1, 0, 5);

    $display("[TB] fill");
    apply_reset();
    for (int k = 1; k <= 16; k++)
      apply_stimulus($sformatf("fill %0d", k), 0, 1'b1, 8'(k), 4, 1'b0, k - 1, 1'b0, 1, 1, 0);
    check_output("count full", 32'(count), 16);
    check_output("full flag", 32'(full), 1);
    apply_stimulus("ins 77 full", 1, 1'b1, 8'h77, 3, 1'b0, -1, 1'b1, 1, 0, 0);
    apply_stimulus("ins 5 full", 0, 1'b1, 8'h05, 3, 1'b1, 4, 1'b0, 1, 0, 0);
    check_output("count saturated", 32'(count), 16);

    $display("[TB] reset during write");
    apply_reset();
    bus.req_valid[0] = 1'b1;
    bus.req_op[0] = 1'b1;
    bus.req_key[7:0] = 8'h42;
    repeat (3) begin
      @(negedge clk);
      bus.req_valid[0] = 1'b0;
    end
    check_output("in WR", 32'(cam_write), 1);
    rst = 1'b1;
    @(negedge clk);
    check_output("abort rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_hit, bus.rsp_err, bus.rsp_idx}), 0);
    check_output("abort strobes", 32'({bus.req_ready, cam_enable, cam_write, cam_addr, cam_data}), 0);
    check_output("abort count", 32'({count, full}), 0);
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check_output("no response after abort", seen, 0);
    apply_stimulus("look 42", 0, 1'b0, 8'h42, 3, 1'b0, 0, 1'b0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
